// File: rtl/systolic_ctrl_pkg.sv
// Shared state encoding and phase-length helpers for the systolic array sequencer.
package systolic_ctrl_pkg;

  parameter int unsigned DataWidth = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StFeed  = 3'd2,
    StFlush = 3'd3,
    StDrain = 3'd4,
    StDone  = 3'd5
  } ctrl_st_e;

  // Cycles for clr to ripple from PE[0][0] to PE[N-1][N-1].
  function automatic int unsigned clr_cyc(input int unsigned n);
    return 2 * n - 1;
  endfunction

  // 2(N-1) hops + 2 cc PE latency + 1 RAM cc.
  function automatic int unsigned flush_cyc(input int unsigned n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_operand_skew.sv
// Triangular delay line: lane i is an i-stage shift register, lane 0 passes straight through.
module systolic_ctrl_operand_skew #(
  parameter int unsigned ARRAY_N    = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clr_i,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] data_i,
  output logic [ARRAY_N*DATA_WIDTH-1:0] data_o
);

  assign data_o[DATA_WIDTH-1:0] = data_i[DATA_WIDTH-1:0];

  for (genvar i = 1; i < ARRAY_N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] r_pipe [0:i-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < i; s++) r_pipe[s] <= '0;
      end else if (clr_i) begin
        for (int s = 0; s < i; s++) r_pipe[s] <= '0;
      end else begin
        r_pipe[0] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
        for (int s = 1; s < i; s++) r_pipe[s] <= r_pipe[s-1];
      end
    end

    assign data_o[i*DATA_WIDTH +: DATA_WIDTH] = r_pipe[i-1];
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the PE grid: clear, feed skewed operands, flush, then drain psum rows.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_N    = 4,
  parameter int unsigned K_W        = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_WIDTH = DataWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  start_i,
  input  logic                                  abort_i,
  input  logic [K_W-1:0]                        k_len_i,
  input  logic [ADDR_W-1:0]                     a_base_i,
  input  logic [ADDR_W-1:0]                     b_base_i,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  rd_en_o,
  output logic [ADDR_W-1:0]                     a_raddr_o,
  output logic [ADDR_W-1:0]                     b_raddr_o,
  input  logic [ARRAY_N*DATA_WIDTH-1:0]         a_rdata_i,
  input  logic [ARRAY_N*DATA_WIDTH-1:0]         b_rdata_i,
  output logic [ARRAY_N*DATA_WIDTH-1:0]         arr_a_o,
  output logic [ARRAY_N*DATA_WIDTH-1:0]         arr_b_o,
  output logic                                  arr_clr_o,
  output logic                                  arr_we_o,
  input  logic [ARRAY_N*ARRAY_N*DATA_WIDTH-1:0] psum_i,
  output logic                                  res_valid_o,
  input  logic                                  res_ready_i,
  output logic [$clog2(ARRAY_N)-1:0]            res_row_o,
  output logic [ARRAY_N*DATA_WIDTH-1:0]         res_data_o
);

  localparam int unsigned ROW_W = $clog2(ARRAY_N);
  localparam logic [K_W-1:0]   ClrLast   = K_W'(clr_cyc(ARRAY_N) - 1);
  localparam logic [K_W-1:0]   FlushLast = K_W'(flush_cyc(ARRAY_N) - 1);
  localparam logic [ROW_W-1:0] RowLast   = ROW_W'(ARRAY_N - 1);

  ctrl_st_e          r_state, w_state_d;
  logic [K_W-1:0]    r_cnt, w_cnt_d;
  logic [K_W-1:0]    r_k_len;
  logic [ADDR_W-1:0] r_a_base, r_b_base;
  logic [ROW_W-1:0]  r_row, w_row_d;
  logic              r_rd_dly;
  logic              r_abort_clr;
  logic              w_abort;

  logic [ARRAY_N*DATA_WIDTH-1:0] w_skew_a, w_skew_b;

  assign w_abort = abort_i && (r_state != StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_row       <= '0;
      r_k_len     <= '0;
      r_a_base    <= '0;
      r_b_base    <= '0;
      r_rd_dly    <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_row       <= w_row_d;
      r_rd_dly    <= rd_en_o && !w_abort;
      r_abort_clr <= w_abort;
      if (r_state == StIdle && start_i && !abort_i) begin
        r_k_len  <= k_len_i;
        r_a_base <= a_base_i;
        r_b_base <= b_base_i;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_row_d     = r_row;
    busy_o      = (r_state != StIdle);
    done_o      = 1'b0;
    rd_en_o     = 1'b0;
    a_raddr_o   = '0;
    b_raddr_o   = '0;
    arr_clr_o   = r_abort_clr;
    arr_we_o    = r_rd_dly;
    res_valid_o = 1'b0;
    res_row_o   = '0;
    res_data_o  = '0;

    unique case (r_state)
      StIdle: begin
        if (start_i && !abort_i) begin
          w_state_d = StClear;
          w_cnt_d   = '0;
        end
      end
      StClear: begin
        arr_clr_o = 1'b1;
        if (r_cnt == ClrLast) begin
          w_cnt_d   = '0;
          w_state_d = (r_k_len == '0) ? StDone : StFeed;
        end else begin
          w_cnt_d = r_cnt + K_W'(1);
        end
      end
      StFeed: begin
        rd_en_o   = 1'b1;
        a_raddr_o = r_a_base + ADDR_W'(r_cnt);
        b_raddr_o = r_b_base + ADDR_W'(r_cnt);
        if (r_cnt == r_k_len - K_W'(1)) begin
          w_cnt_d   = '0;
          w_state_d = StFlush;
        end else begin
          w_cnt_d = r_cnt + K_W'(1);
        end
      end
      StFlush: begin
        arr_we_o = 1'b1;
        if (r_cnt == FlushLast) begin
          w_cnt_d   = '0;
          w_row_d   = '0;
          w_state_d = StDrain;
        end else begin
          w_cnt_d = r_cnt + K_W'(1);
        end
      end
      StDrain: begin
        res_valid_o = 1'b1;
        res_row_o   = r_row;
        for (int unsigned r = 0; r < ARRAY_N; r++) begin
          if (r_row == ROW_W'(r)) begin
            res_data_o = psum_i[r*ARRAY_N*DATA_WIDTH +: ARRAY_N*DATA_WIDTH];
          end
        end
        if (res_ready_i) begin
          if (r_row == RowLast) w_state_d = StDone;
          else                  w_row_d   = r_row + ROW_W'(1);
        end
      end
      StDone: begin
        done_o    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    if (w_abort) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
      w_row_d   = '0;
    end
  end

  // Read data is only meaningful the cycle after a read; otherwise feed zeros.
  assign w_skew_a = r_rd_dly ? a_rdata_i : '0;
  assign w_skew_b = r_rd_dly ? b_rdata_i : '0;

  systolic_ctrl_operand_skew #(
    .ARRAY_N    (ARRAY_N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_abort),
    .data_i (w_skew_a),
    .data_o (arr_a_o)
  );

  systolic_ctrl_operand_skew #(
    .ARRAY_N    (ARRAY_N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_abort),
    .data_i (w_skew_b),
    .data_o (arr_b_o)
  );

endmodule
